pipe_shifter: RTL and testbench
===============================

PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 Parameter WIDTH, default 32, data width; SHALL be a power of two, 8..64.
REQ-002 Parameter STAGES, default 2, pipeline register stages; SHALL satisfy 1 <= STAGES <= log2(WIDTH).
REQ-003 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port in_valid, input, 1, input beat present.
REQ-006 Port in_ready, output, 1, block accepts input beat this cycle.
REQ-007 Port in_data, input, WIDTH, operand.
REQ-008 Port in_shamt, input, log2(WIDTH), shift amount.
REQ-009 Port in_op, input, 3, operation code.
REQ-010 Port out_valid, output, 1, result beat present.
REQ-011 Port out_ready, input, 1, consumer accepts result.
REQ-012 Port out_data, output, WIDTH, result.
REQ-013 Port out_err, output, 1, result came from a reserved op code.

Function
REQ-014 Op codes: 000 SLL, 001 SRL, 010 SRA (fill with in_data[WIDTH-1]), 011 ROL, 100 ROR; 101-111 reserved.
REQ-015 Reserved op: out_data equals in_data unshifted; out_err = 1. Legal ops: out_err = 0.
REQ-016 Shamt 0: out_data equals in_data for every op.
REQ-017 Logical fill bits: 0. Rotates: no bits lost; ROL by n equals ROR by WIDTH-n.
REQ-018 Shift built as log2(WIDTH) mux layers; layer k shifts by 2^k when shamt bit k set.
REQ-019 Layers split across STAGES: each stage holds ceil(log2(WIDTH)/STAGES) layers, lowest bits first; last stage takes the remainder.
REQ-020 Each stage register holds valid, partial data, remaining shamt bits, op, sign bit, err flag.
REQ-021 Input transfer occurs when in_valid and in_ready are both 1; output transfer when out_valid and out_ready are both 1.
REQ-022 Latency: exactly STAGES cycles from input transfer to out_valid, with no stall.
REQ-023 Throughput: one beat per cycle while out_ready = 1.
REQ-024 Stage i advances when stage i+1 is empty or advancing; last stage advances when empty or out_ready = 1.
REQ-025 in_ready = stage 0 empty or stage 0 advancing; combinational from out_ready, no registered ready.
REQ-026 Bubble collapse: empty stages fill while downstream stages are stalled.
REQ-027 Stall: out_valid = 1 with out_ready = 0 holds out_data, out_err and all full stages stable.
REQ-028 Accept and emit in the same cycle with a full pipeline: no beat lost or duplicated; order preserved.
REQ-029 Inputs are sampled only at transfer; changes while in_ready = 0 have no effect.
REQ-030 out_data and out_err are don't-care when out_valid = 0.

Reset
REQ-031 rst_n low SHALL immediately clear all stage valid bits; out_valid = 0, in_ready = 1.
REQ-032 On reset, data registers SHALL clear to 0; out_data = 0, out_err = 0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight beats; none emerge after release.
REQ-034 First transfer is allowed on the first rising edge after rst_n deasserts.

Structure
REQ-035 Package pipe_shifter_pkg SHALL hold the op-code constants/enum and a clog2-based shamt-width helper.
REQ-036 One sub-module, pipe_shifter_layer: one combinational layer (data, shift bit, op, sign, layer index -> data); instantiated log2(WIDTH) times.
REQ-037 Stage registers and handshake logic SHALL live in pipe_shifter via a generate loop over STAGES.

Verification
REQ-038 WIDTH=32, STAGES=2: SRA 0x80000000 by 4 -> 0xF8000000 two cycles later; SRL same -> 0x08000000.
REQ-039 ROL 0x80000001 by 1 -> 0x00000003; ROR 0x00000001 by 31 -> 0x00000002; SLL 0x1 by 31 -> 0x80000000.
REQ-040 Op 111, data 0x12345678, shamt 5 -> out_data 0x12345678, out_err = 1.
REQ-041 Stream 8 back-to-back beats with out_ready low for cycles 3-5 -> all 8 results in order; in_ready low only while the pipeline is full.
REQ-042 Assert rst_n low with 2 beats in flight -> out_valid = 0 immediately; no result after release.
REQ-043 Sweep WIDTH=8 and 64 with STAGES=1 and log2(WIDTH), random op/shamt, against a reference model -> zero mismatches.

Source files
------------

// File: rtl/pipe_shifter_pkg.sv
// Shared op-code encoding and shift-amount width helper for the pipelined shifter.
package pipe_shifter_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } shift_op_e;

  localparam int unsigned OP_W = 3;

  function automatic int unsigned shamt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/pipe_shifter_layer.sv
// One combinational shift layer: moves data by 2**LAYER positions when shift_en is set.
module pipe_shifter_layer
  import pipe_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LAYER = 0
) (
  input  logic [WIDTH-1:0]  data_i,
  input  logic              shift_en,
  input  logic [OP_W-1:0]   op,
  input  logic              sign,
  output logic [WIDTH-1:0]  data_o
);

  localparam int unsigned AMT = 1 << LAYER;

  always_comb begin
    data_o = data_i;
    if (shift_en) begin
      case (op)
        OP_SLL:  data_o = {data_i[WIDTH-1-AMT:0], {AMT{1'b0}}};
        OP_SRL:  data_o = {{AMT{1'b0}}, data_i[WIDTH-1:AMT]};
        OP_SRA:  data_o = {{AMT{sign}}, data_i[WIDTH-1:AMT]};
        OP_ROL:  data_o = {data_i[WIDTH-1-AMT:0], data_i[WIDTH-1:WIDTH-AMT]};
        OP_ROR:  data_o = {data_i[AMT-1:0], data_i[WIDTH-1:AMT]};
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter with valid/ready handshake; shift layers are spread
// across STAGES register stages, lowest shamt bits first.
module pipe_shifter
  import pipe_shifter_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  logic [shamt_width(WIDTH)-1:0] in_shamt,
  input  logic [OP_W-1:0]               in_op,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_err
);

  localparam int unsigned LW  = shamt_width(WIDTH);
  localparam int unsigned LPS = (LW + STAGES - 1) / STAGES;

  logic [STAGES-1:0]            stg_valid;
  logic [STAGES-1:0]            stg_adv;
  logic [STAGES-1:0]            stg_sign;
  logic [STAGES-1:0]            stg_err;
  logic [STAGES-1:0][WIDTH-1:0] stg_data;
  logic [STAGES-1:0][LW-1:0]    stg_shamt;
  logic [STAGES-1:0][OP_W-1:0]  stg_op;

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin : p_advance
    logic [STAGES-1:0] adv;
    adv = '0;
    adv[STAGES-1] = !stg_valid[STAGES-1] || out_ready;
    for (int unsigned i = 1; i < STAGES; i++) begin
      adv[STAGES-1-i] = !stg_valid[STAGES-1-i] || adv[STAGES-i];
    end
    stg_adv = adv;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned LO = s * LPS;
    localparam int unsigned HI = ((s + 1) * LPS > LW) ? LW : (s + 1) * LPS;
    localparam int unsigned NL = (HI > LO) ? HI - LO : 0;
    localparam logic [LW-1:0] DONE = LW'((64'd1 << HI) - 64'd1);

    logic             src_valid;
    logic             src_sign;
    logic             src_err;
    logic [WIDTH-1:0] src_data;
    logic [LW-1:0]    src_shamt;
    logic [OP_W-1:0]  src_op;

    if (s == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in_data;
      assign src_shamt = in_shamt;
      assign src_op    = in_op;
      assign src_sign  = in_data[WIDTH-1];
      assign src_err   = (in_op > OP_ROR);
    end else begin : g_body
      assign src_valid = stg_valid[s-1];
      assign src_data  = stg_data[s-1];
      assign src_shamt = stg_shamt[s-1];
      assign src_op    = stg_op[s-1];
      assign src_sign  = stg_sign[s-1];
      assign src_err   = stg_err[s-1];
    end

    logic [WIDTH-1:0] chain [NL+1];
    assign chain[0] = src_data;

    for (genvar l = 0; l < NL; l++) begin : g_layer
      pipe_shifter_layer #(
        .WIDTH (WIDTH),
        .LAYER (LO + l)
      ) u_layer (
        .data_i   (chain[l]),
        .shift_en (src_shamt[LO+l]),
        .op       (src_op),
        .sign     (src_sign),
        .data_o   (chain[l+1])
      );
    end

    logic             valid_q, valid_d;
    logic             sign_q, sign_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [LW-1:0]    shamt_q, shamt_d;
    logic [OP_W-1:0]  op_q, op_d;

    // Consumed shamt bits are cleared so only the remaining layers' bits travel on.
    always_comb begin
      valid_d = valid_q;
      sign_d  = sign_q;
      err_d   = err_q;
      data_d  = data_q;
      shamt_d = shamt_q;
      op_d    = op_q;
      if (stg_adv[s]) begin
        valid_d = src_valid;
        sign_d  = src_sign;
        err_d   = src_err;
        data_d  = chain[NL];
        shamt_d = src_shamt & ~DONE;
        op_d    = src_op;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        sign_q  <= 1'b0;
        err_q   <= 1'b0;
        data_q  <= '0;
        shamt_q <= '0;
        op_q    <= '0;
      end else begin
        valid_q <= valid_d;
        sign_q  <= sign_d;
        err_q   <= err_d;
        data_q  <= data_d;
        shamt_q <= shamt_d;
        op_q    <= op_d;
      end
    end

    assign stg_valid[s] = valid_q;
    assign stg_sign[s]  = sign_q;
    assign stg_err[s]   = err_q;
    assign stg_data[s]  = data_q;
    assign stg_shamt[s] = shamt_q;
    assign stg_op[s]    = op_q;
  end

  assign in_ready  = stg_adv[0];
  assign out_valid = stg_valid[STAGES-1];
  assign out_data  = stg_data[STAGES-1];
  assign out_err   = stg_err[STAGES-1];

  // Last-stage control fields have no further consumer.
  logic unused_tail;
  assign unused_tail = ^{stg_shamt[STAGES-1], stg_op[STAGES-1], stg_sign[STAGES-1]};

endmodule

// File: tb/tb_pipe_shifter.sv
// Scoreboard bench for pipe_shifter: directed 32-bit vectors plus 8/64-bit sweeps.
module tb_pipe_shifter;

  localparam int unsigned STAGES = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt;
  logic [2:0]  in_op;

  int n_tests = 0;
  int n_fail  = 0;
  bit sweep_go = 0;
  int sweep_done = 0;

  logic [32:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_shifter #(.WIDTH(32), .STAGES(STAGES)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [64:0] ref_shift(input int unsigned w, input logic [63:0] d,
                                            input int unsigned sh, input logic [2:0] op);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < w; i++) begin
      case (op)
        3'd0: if (i >= sh) r[i] = d[i-sh];
        3'd1: if (i + sh < w) r[i] = d[i+sh];
        3'd2: if (i + sh < w) r[i] = d[i+sh]; else r[i] = d[w-1];
        3'd3: r[i] = d[(i + w - sh) % w];
        3'd4: r[i] = d[(i + sh) % w];
        default: r[i] = d[i];
      endcase
    end
    return {op > 3'd4, r};
  endfunction

  // Directed vectors: data, shamt, op, expected data, expected err (hand-computed).
  logic [31:0] v_d   [14] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0001, 32'h0000_0001,
                              32'h0000_0001, 32'h1234_5678, 32'h7FFF_0000, 32'hDEAD_BEEF,
                              32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_00A5,
                              32'h0000_F00F, 32'h0000_F00F};
  logic [4:0]  v_sh  [14] = '{5'd4, 5'd4, 5'd1, 5'd31, 5'd31, 5'd5, 5'd16, 5'd0,
                              5'd8, 5'd8, 5'd31, 5'd0, 5'd4, 5'd28};
  logic [2:0]  v_op  [14] = '{3'd2, 3'd1, 3'd3, 3'd4, 3'd0, 3'd7, 3'd2, 3'd3,
                              3'd4, 3'd0, 3'd2, 3'd5, 3'd3, 3'd4};
  logic [31:0] v_exp [14] = '{32'hF800_0000, 32'h0800_0000, 32'h0000_0003, 32'h0000_0002,
                              32'h8000_0000, 32'h1234_5678, 32'h0000_7FFF, 32'hDEAD_BEEF,
                              32'h7812_3456, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h0000_00A5,
                              32'h000F_00F0, 32'h000F_00F0};
  logic        v_err [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  // Called at posedge+#1; returns at posedge+#1 just after the transfer edge.
  task automatic send(input int idx);
    int unsigned waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = v_d[idx];
    in_shamt = v_sh[idx];
    in_op    = v_op[idx];
    @(negedge clk);
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: vector %0d never accepted", idx);
    end else begin
      exp_q.push_back({v_err[idx], v_exp[idx]});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor for the 32-bit instance.
  int          occ = 0;
  bit          have_hold = 0;
  logic [32:0] hold;
  always @(negedge clk) begin
    if (!rst_n) begin
      occ       = 0;
      have_hold = 0;
    end else begin
      check("in_ready", 65'(in_ready), 65'(!(occ == int'(STAGES) && !out_ready)));
      if (have_hold)
        check("stall_hold", {31'b0, out_valid, out_err, out_data}, {31'b0, 1'b1, hold});
      have_hold = out_valid && !out_ready;
      hold      = {out_err, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got %h with no beat pending", {out_err, out_data});
        end else begin
          check("result", {32'b0, out_err, out_data}, {32'b0, exp_q.pop_front()});
        end
      end
      occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
    end
  end

  // Width/stage sweeps against the bit-level reference model.
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int unsigned W  = (g < 2) ? 8 : 64;
    localparam int unsigned S  = (g % 2 == 0) ? 1 : $clog2(W);
    localparam int unsigned LW = $clog2(W);

    logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_err;
    logic [W-1:0]  s_in_data, s_out_data;
    logic [LW-1:0] s_in_shamt;
    logic [2:0]    s_in_op;
    logic [64:0]   s_q[$];
    bit            s_done = 0;

    pipe_shifter #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_data   (s_in_data),
      .in_shamt  (s_in_shamt),
      .in_op     (s_in_op),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_data  (s_out_data),
      .out_err   (s_out_err)
    );

    initial begin : stim
      logic [63:0] d;
      int unsigned sh;
      logic [2:0]  op;
      int unsigned waited;
      s_in_valid = 1'b0;
      s_in_data  = '0;
      s_in_shamt = '0;
      s_in_op    = '0;
      wait (sweep_go);
      @(posedge clk);
      #1;
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(3, 0) == 0) begin
          @(posedge clk);
          #1;
        end
        d  = {$urandom, $urandom};
        d  = 64'(W'(d));
        sh = $urandom_range(W - 1, 0);
        op = 3'($urandom_range(7, 0));
        s_in_valid = 1'b1;
        s_in_data  = W'(d);
        s_in_shamt = LW'(sh);
        s_in_op    = op;
        waited = 0;
        @(negedge clk);
        while (!s_in_ready && waited < 100) begin
          @(negedge clk);
          waited++;
        end
        if (!s_in_ready) begin
          n_tests++;
          n_fail++;
          $display("FAIL sweep_send_timeout: W=%0d S=%0d beat %0d", W, S, i);
        end else begin
          s_q.push_back(ref_shift(W, d, sh, op));
        end
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
      end
      waited = 0;
      while (s_q.size() != 0 && waited < 400) begin
        @(posedge clk);
        waited++;
      end
      if (s_q.size() != 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sweep_drain: W=%0d S=%0d %0d beats left, 0 required", W, S, s_q.size());
      end
      s_done = 1;
      sweep_done++;
    end

    initial begin : ready_drv
      s_out_ready = 1'b1;
      wait (sweep_go);
      while (!s_done) begin
        @(posedge clk);
        #1;
        s_out_ready = ($urandom_range(3, 0) != 0);
      end
      s_out_ready = 1'b1;
    end

    always @(negedge clk) begin
      if (rst_n && s_out_valid && s_out_ready) begin
        if (s_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sweep_unexpected: W=%0d S=%0d got %h", W, S, s_out_data);
        end else begin
          check($sformatf("sweep_w%0d_s%0d", W, S), {s_out_err, 64'(s_out_data)}, s_q.pop_front());
        end
      end
    end
  end

  initial begin : main
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b1;
    #12;
    check("reset_out_valid", 65'(out_valid), 65'(0));
    check("reset_in_ready", 65'(in_ready), 65'(1));
    check("reset_out_data", 65'(out_data), 65'(0));
    check("reset_out_err", 65'(out_err), 65'(0));

    // Release between edges; the very next rising edge takes the first beat.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(0);
    @(negedge clk);
    check("latency_cycle1", 65'(out_valid), 65'(0));
    @(negedge clk);
    check("latency_cycle2", 65'(out_valid), 65'(1));
    @(posedge clk);
    #1;

    // Eight back-to-back beats with the consumer stalled for three cycles.
    fork
      begin
        for (int i = 1; i <= 8; i++) send(i);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join

    for (int i = 9; i < 14; i++) send(i);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_main", 65'(exp_q.size()), 65'(0));

    // Two beats in flight, then asynchronous reset.
    @(posedge clk);
    #1;
    send(0);
    send(1);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 65'(out_valid), 65'(0));
    check("midreset_in_ready", 65'(in_ready), 65'(1));
    check("midreset_out_data", 65'(out_data), 65'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_reset_no_out", 65'(out_valid), 65'(0));

    sweep_go = 1;
    for (int i = 0; i < 5000 && sweep_done < 4; i++) @(posedge clk);
    if (sweep_done < 4) begin
      n_tests++;
      n_fail++;
      $display("FAIL sweep_timeout: %0d sweeps finished, 4 required", sweep_done);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
